// File: rtl/regfile_fault_sequencer_if.sv
// Request and command bundle between a fault-injection client, the sequencer and the register file.
// master: the request source / command observer; slave: the sequencer itself.
// Plain wires, no storage; flow control is req_valid/req_ready on the request side only.
interface regfile_fault_sequencer_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_WORDS     = 32,
  parameter int COMMAND_WIDTH = 4
);
  localparam int BW = $clog2(DATA_WIDTH);

  logic                     req_valid;
  logic                     req_ready;
  logic [4:0]               req_reg;
  logic [BW-1:0]            req_bit;
  logic [15:0]              req_delay;
  logic [7:0]               req_count;
  logic [15:0]              req_interval;

  logic                     cmd_valid;
  logic [COMMAND_WIDTH-1:0] cmd_command;
  logic [NUM_WORDS-1:0]     cmd_data0;
  logic [DATA_WIDTH-1:0]    cmd_data1;

  modport master (
    output req_valid, req_reg, req_bit, req_delay, req_count, req_interval,
    input  req_ready, cmd_valid, cmd_command, cmd_data0, cmd_data1
  );

  modport slave (
    input  req_valid, req_reg, req_bit, req_delay, req_count, req_interval,
    output req_ready, cmd_valid, cmd_command, cmd_data0, cmd_data1
  );
endinterface

// File: rtl/regfile_fault_sequencer.sv
// Fault-injection sequencer: after a programmed delay, issues N spaced bit-flip commands, or a one-shot check.
// Latency: first flip delay+1 cycles after accept; flips spaced max(interval, MIN_GAP) cycles apart.
// Backpressure: req_ready is high only in IDLE; the command port has no ready and never stalls.
module regfile_fault_sequencer #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_WORDS     = 32,
  parameter int COMMAND_WIDTH = 4,
  parameter int MIN_GAP       = 2,
  parameter int SKIP_ZERO_REG = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  regfile_fault_sequencer_if.slave bus,
  input  logic        abort_i,
  input  logic        chk_req_i,
  input  logic        state0_i,
  output logic        state0_q_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        aborted_o,
  output logic [15:0] flips_total_o
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [15:0] MIN_GAP_W = 16'(MIN_GAP);
  localparam logic [COMMAND_WIDTH-1:0] CMD_NONE  = COMMAND_WIDTH'(0);
  localparam logic [COMMAND_WIDTH-1:0] CMD_FLIP  = COMMAND_WIDTH'(1);
  localparam logic [COMMAND_WIDTH-1:0] CMD_CHECK = COMMAND_WIDTH'(2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DELAY = 3'd1;
  localparam logic [2:0] S_FIRE  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [4:0]    reg_q;
  logic [BW-1:0] bit_q;
  logic [15:0]   ivl_q;    // stored spacing minus one
  logic [15:0]   rem_q;    // flips still to issue
  logic [15:0]   ctr_q;    // delay / holdoff countdown
  logic [15:0]   total_q;
  logic          done_q, err_q, abort_q, s0_q;

  logic          accept, reject, fire_ok, abort_hit, last_flip;
  logic [15:0]   ivl_eff, ivl_store, count_eff;

  assign accept    = bus.req_valid && (state_q == S_IDLE);
  assign reject    = accept && (SKIP_ZERO_REG != 0) && (bus.req_reg == 5'd0);
  // An abort landing on the flip cycle kills the flip outright.
  assign fire_ok   = (state_q == S_FIRE) && !abort_i;
  assign abort_hit = abort_i && ((state_q == S_DELAY) || (state_q == S_FIRE) || (state_q == S_HOLD));
  assign last_flip = (rem_q <= 16'd1);

  assign ivl_eff   = (bus.req_interval < MIN_GAP_W) ? MIN_GAP_W : bus.req_interval;
  assign ivl_store = ivl_eff - 16'd1;
  assign count_eff = {8'd0, (bus.req_count == 8'd0) ? 8'd1 : bus.req_count};

  // Next-state decode; a request beats a simultaneous check request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !reject)   state_d = S_DELAY;
        else if (!accept && chk_req_i) state_d = S_CHECK;
      end
      S_DELAY: begin
        if (abort_i)             state_d = S_IDLE;
        else if (ctr_q == 16'd0) state_d = S_FIRE;
      end
      S_FIRE: begin
        if (abort_i || last_flip) state_d = S_IDLE;
        else if (ivl_q == 16'd0)  state_d = S_FIRE;
        else                      state_d = S_HOLD;
      end
      S_HOLD: begin
        if (abort_i)             state_d = S_IDLE;
        else if (ctr_q == 16'd0) state_d = S_FIRE;
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latched request and the delay/holdoff/remaining counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_q <= '0;
      bit_q <= '0;
      ivl_q <= '0;
      rem_q <= '0;
      ctr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            reg_q <= bus.req_reg;
            bit_q <= bus.req_bit;
            ivl_q <= ivl_store;
            rem_q <= count_eff;
            ctr_q <= bus.req_delay;
          end
        end
        S_DELAY, S_HOLD: begin
          if (ctr_q != 16'd0) ctr_q <= ctr_q - 16'd1;
        end
        S_FIRE: begin
          if (!abort_i) begin
            rem_q <= rem_q - 16'd1;
            // Holdoff lasts ivl_q cycles so flip-to-flip spacing is ivl_q+1.
            if (ivl_q != 16'd0) ctr_q <= ivl_q - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status pulses, saturating flip total and the state0 mirror.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      total_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      s0_q    <= 1'b0;
    end else begin
      if (fire_ok && (total_q != 16'hFFFF)) total_q <= total_q + 16'd1;
      done_q  <= fire_ok && last_flip;
      err_q   <= reject;
      abort_q <= abort_hit;
      s0_q    <= state0_i;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign busy_o          = (state_q != S_IDLE);
  assign bus.cmd_valid   = fire_ok || (state_q == S_CHECK);
  assign bus.cmd_command = fire_ok ? CMD_FLIP : ((state_q == S_CHECK) ? CMD_CHECK : CMD_NONE);
  assign bus.cmd_data0   = fire_ok ? NUM_WORDS'(reg_q) : '0;
  assign bus.cmd_data1   = fire_ok ? DATA_WIDTH'(bit_q) : '0;

  assign state0_q_o    = s0_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign aborted_o     = abort_q;
  assign flips_total_o = total_q;

endmodule

// File: tb/tb_regfile_fault_sequencer.sv
// Directed bench for regfile_fault_sequencer: table of flip requests plus hand sequences.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Every wait is a fixed number of clock cycles.
module tb_regfile_fault_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        abort_i, chk_req_i, state0_i;
  logic        state0_q_o, busy_o, done_o, err_o, aborted_o;
  logic [15:0] flips_total_o;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_total = 0;

  regfile_fault_sequencer_if #(.DATA_WIDTH(64), .NUM_WORDS(32), .COMMAND_WIDTH(4)) bus ();

  regfile_fault_sequencer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus),
    .abort_i       (abort_i),
    .chk_req_i     (chk_req_i),
    .state0_i      (state0_i),
    .state0_q_o    (state0_q_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .aborted_o     (aborted_o),
    .flips_total_o (flips_total_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle numbers count from 0 = the period right after the accept edge.
  typedef struct {
    logic [4:0] rg;
    logic [5:0] bt;
    int dly, cnt, ivl;
    int abort_k;              // period in which abort_i is held (0 = never)
    int n, first, sp;         // pulses actually expected, first period, spacing
    int done_c, abort_c;      // period of done_o / aborted_o pulse (0 = none)
    int idle_c;               // first period with req_ready_o back high
    int delta;                // flips added to the total
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_reg = '0; bus.req_bit = '0;
    bus.req_delay = '0; bus.req_count = '0; bus.req_interval = '0;
    abort_i = 1'b0; chk_req_i = 1'b0;
  endtask

  // Present a request in the current period; returns just after the accept edge.
  task automatic send_req(input logic [4:0] rg, input logic [5:0] bt, input int dly,
                          input int cnt, input int ivl);
    bus.req_valid = 1'b1; bus.req_reg = rg; bus.req_bit = bt;
    bus.req_delay = 16'(dly); bus.req_count = 8'(cnt); bus.req_interval = 16'(ivl);
    @(posedge clk_i); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int win;
    logic is_p;
    win = ((v.done_c > v.abort_c) ? v.done_c : v.abort_c) + 2;
    send_req(v.rg, v.bt, v.dly, v.cnt, v.ivl);
    for (int k = 0; k <= win; k++) begin
      abort_i = (v.abort_k != 0 && k == v.abort_k);
      @(negedge clk_i);
      is_p = 1'b0;
      for (int i = 0; i < v.n; i++) if (k == v.first + i * v.sp) is_p = 1'b1;
      chk($sformatf("v%0d k%0d cmd_valid", vi, k), 64'(bus.cmd_valid), 64'(is_p));
      chk($sformatf("v%0d k%0d cmd_command", vi, k), 64'(bus.cmd_command), is_p ? 64'd1 : 64'd0);
      chk($sformatf("v%0d k%0d cmd_data0", vi, k), 64'(bus.cmd_data0), is_p ? 64'(v.rg) : 64'd0);
      chk($sformatf("v%0d k%0d cmd_data1", vi, k), bus.cmd_data1, is_p ? 64'(v.bt) : 64'd0);
      chk($sformatf("v%0d k%0d done", vi, k), 64'(done_o), 64'(v.done_c != 0 && k == v.done_c));
      chk($sformatf("v%0d k%0d aborted", vi, k), 64'(aborted_o), 64'(v.abort_c != 0 && k == v.abort_c));
      chk($sformatf("v%0d k%0d err", vi, k), 64'(err_o), 64'd0);
      chk($sformatf("v%0d k%0d req_ready", vi, k), 64'(bus.req_ready), 64'(k >= v.idle_c));
      @(posedge clk_i); #1;
    end
    abort_i = 1'b0;
    exp_total += v.delta;
    chk($sformatf("v%0d flips_total", vi), 64'(flips_total_o), 64'(exp_total));
  endtask

  initial begin
    //          rg     bt    dly cnt ivl abk  n first sp done abt idle delta
    vecs[0] = '{5'd5,  6'd3,  0,  1,  0,  0,  1,  1,  1,  2,  0,  2,  1};
    vecs[1] = '{5'd7,  6'd63, 10, 3,  4,  0,  3, 11,  4, 20,  0, 20,  3};
    vecs[2] = '{5'd1,  6'd0,  2,  2,  0,  0,  2,  3,  2,  6,  0,  6,  2};
    vecs[3] = '{5'd31, 6'd10, 1,  0,  7,  0,  1,  2,  7,  3,  0,  3,  1};
    vecs[4] = '{5'd9,  6'd42, 3,  3,  5,  9,  1,  4,  5,  0, 10, 10,  1};
    vecs[5] = '{5'd2,  6'd1,  0,  3,  1,  0,  3,  1,  2,  6,  0,  6,  3};

    idle_inputs();
    state0_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("rst cmd_command", 64'(bus.cmd_command), 64'd0);
    chk("rst total", 64'(flips_total_o), 64'd0);
    chk("rst pulses", {61'd0, done_o, err_o, aborted_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int vi = 0; vi < 6; vi++) run_vec(vi, vecs[vi]);

    // Register-0 request is rejected: err_o pulse, nothing fired.
    send_req(5'd0, 6'd5, 0, 1, 0);
    @(negedge clk_i);
    chk("rej err", 64'(err_o), 64'd1);
    chk("rej cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("rej ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rej err drop", 64'(err_o), 64'd0);
    chk("rej cmd_valid2", 64'(bus.cmd_valid), 64'd0);

    // Rejected request alongside chk_req_i: the request wins, no check issued.
    chk_req_i = 1'b1;
    send_req(5'd0, 6'd1, 0, 1, 0);
    chk_req_i = 1'b0;
    @(negedge clk_i);
    chk("prio cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("prio err", 64'(err_o), 64'd1);
    @(posedge clk_i); #1;

    // Check command with state0 mirror.
    chk_req_i = 1'b1; state0_i = 1'b1;
    @(posedge clk_i); #1;
    chk_req_i = 1'b0;
    @(negedge clk_i);
    chk("check cmd_valid", 64'(bus.cmd_valid), 64'd1);
    chk("check cmd_command", 64'(bus.cmd_command), 64'd2);
    chk("check data0", 64'(bus.cmd_data0), 64'd0);
    chk("check data1", bus.cmd_data1, 64'd0);
    chk("check state0_q", 64'(state0_q_o), 64'd1);
    chk("check busy", 64'(busy_o), 64'd1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("check after valid", 64'(bus.cmd_valid), 64'd0);
    chk("check after ready", 64'(bus.req_ready), 64'd1);
    chk("check total", 64'(flips_total_o), 64'(exp_total));

    // Abort while idle is ignored.
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    @(negedge clk_i);
    chk("idle abort aborted", 64'(aborted_o), 64'd0);
    chk("idle abort busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;

    // Reset in the middle of a holdoff: everything clears at once, no more pulses.
    send_req(5'd4, 6'd4, 0, 3, 6);
    @(negedge clk_i);
    chk("rh k0 busy", 64'(busy_o), 64'd1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rh k1 cmd_valid", 64'(bus.cmd_valid), 64'd1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rh k2 total", 64'(flips_total_o), 64'(exp_total + 1));
    chk("rh k2 cmd_valid", 64'(bus.cmd_valid), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    chk("rh rst total", 64'(flips_total_o), 64'd0);
    chk("rh rst ready", 64'(bus.req_ready), 64'd1);
    chk("rh rst busy", 64'(busy_o), 64'd0);
    chk("rh rst cmd_valid", 64'(bus.cmd_valid), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      chk($sformatf("rh post k%0d cmd_valid", k), 64'(bus.cmd_valid), 64'd0);
      chk($sformatf("rh post k%0d done", k), 64'(done_o), 64'd0);
    end
    chk("rh post total", 64'(flips_total_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
